// File: rtl/shot_pkg.sv
// Shared types and board-geometry defaults for the shot mover and its collision controller.
package shot_pkg;

  localparam int DEF_BOARD_LEFT        = 32;
  localparam int DEF_BOARD_TOP         = 160;
  localparam int DEF_BOARD_RIGHT       = 607;
  localparam int DEF_BOARD_BOTTOM      = 479;
  localparam int DEF_SHOT_SIZE         = 8;
  localparam int DEF_MAX_FLIGHT_FRAMES = 60;

  typedef enum logic [1:0] {
    HIT_NONE     = 2'b00,
    HIT_MONSTER  = 2'b01,
    HIT_OBSTACLE = 2'b10,
    HIT_EXPIRED  = 2'b11
  } hit_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLYING = 2'b01,
    RETIRE = 2'b10
  } state_e;

endpackage

// File: rtl/shot_frame_accum.sv
// Sticky per-frame overlap flags between the shot sprite and monsters / obstacles.
module shot_frame_accum
  import shot_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_of_frame,
  input  logic shot_dr,
  input  logic monster_dr,
  input  logic dirt_dr,
  input  logic bag_dr,
  output logic mon_seen,
  output logic obs_seen
);

  logic mon_seen_d, mon_seen_q;
  logic obs_seen_d, obs_seen_q;
  logic mon_hit, obs_hit;

  assign mon_hit = shot_dr & monster_dr;
  assign obs_hit = shot_dr & (dirt_dr | bag_dr);

  // On the frame pulse the old value is consumed; this cycle's overlap seeds the new frame.
  always_comb begin
    mon_seen_d = mon_seen_q | mon_hit;
    obs_seen_d = obs_seen_q | obs_hit;
    if (start_of_frame) begin
      mon_seen_d = mon_hit;
      obs_seen_d = obs_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_seen_q <= 1'b0;
      obs_seen_q <= 1'b0;
    end else begin
      mon_seen_q <= mon_seen_d;
      obs_seen_q <= obs_seen_d;
    end
  end

  assign mon_seen = mon_seen_q;
  assign obs_seen = obs_seen_q;

endmodule

// File: rtl/shot_collision_ctrl.sv
// Decides once per frame whether the live shot must retire, and why.
module shot_collision_ctrl
  import shot_pkg::*;
#(
  parameter int BOARD_LEFT        = DEF_BOARD_LEFT,
  parameter int BOARD_TOP         = DEF_BOARD_TOP,
  parameter int BOARD_RIGHT       = DEF_BOARD_RIGHT,
  parameter int BOARD_BOTTOM      = DEF_BOARD_BOTTOM,
  parameter int SHOT_SIZE         = DEF_SHOT_SIZE,
  parameter int MAX_FLIGHT_FRAMES = DEF_MAX_FLIGHT_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        shot_alive,
  input  logic [10:0] shot_topLeftX,
  input  logic [10:0] shot_topLeftY,
  input  logic        shot_dr,
  input  logic        monster_dr,
  input  logic        dirt_dr,
  input  logic        bag_dr,
  output logic        fireCollision,
  output logic        monster_hit,
  output logic [1:0]  hit_type
);

  localparam int CNT_W = $clog2(MAX_FLIGHT_FRAMES + 1);

  logic mon_seen, obs_seen;

  shot_frame_accum u_accum (
    .clk            (clk),
    .rst            (reset),
    .start_of_frame (startOfFrame),
    .shot_dr        (shot_dr),
    .monster_dr     (monster_dr),
    .dirt_dr        (dirt_dr),
    .bag_dr         (bag_dr),
    .mon_seen       (mon_seen),
    .obs_seen       (obs_seen)
  );

  // 12-bit extension keeps the far-edge sums from wrapping back into the board.
  logic [11:0] x_ext, y_ext, x_far, y_far;
  logic        out_of_bounds;

  assign x_ext = {1'b0, shot_topLeftX};
  assign y_ext = {1'b0, shot_topLeftY};
  assign x_far = x_ext + 12'(SHOT_SIZE - 1);
  assign y_far = y_ext + 12'(SHOT_SIZE - 1);

  assign out_of_bounds = (x_ext < 12'(BOARD_LEFT))  || (y_ext < 12'(BOARD_TOP)) ||
                         (x_far > 12'(BOARD_RIGHT)) || (y_far > 12'(BOARD_BOTTOM));

  state_e           state_d, state_q;
  hit_type_e        hit_type_d, hit_type_q;
  logic             fire_d, fire_q;
  logic             monster_hit_d, monster_hit_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic             expired;

  assign cnt_inc = (cnt_q == CNT_W'(MAX_FLIGHT_FRAMES)) ? cnt_q : cnt_q + CNT_W'(1);
  assign expired = (cnt_inc == CNT_W'(MAX_FLIGHT_FRAMES));

  always_comb begin
    state_d       = state_q;
    hit_type_d    = hit_type_q;
    fire_d        = fire_q;
    monster_hit_d = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        fire_d = 1'b0;
        if (shot_alive) state_d = FLYING;
      end
      FLYING: begin
        if (!shot_alive) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (startOfFrame) begin
          cnt_d = cnt_inc;
          if (mon_seen) begin
            state_d       = RETIRE;
            fire_d        = 1'b1;
            monster_hit_d = 1'b1;
            hit_type_d    = HIT_MONSTER;
          end else if (obs_seen) begin
            state_d    = RETIRE;
            fire_d     = 1'b1;
            hit_type_d = HIT_OBSTACLE;
          end else if (out_of_bounds || expired) begin
            state_d    = RETIRE;
            fire_d     = 1'b1;
            hit_type_d = HIT_EXPIRED;
          end
        end
      end
      RETIRE: begin
        if (!shot_alive) begin
          fire_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fire_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hit_type_q    <= HIT_NONE;
      fire_q        <= 1'b0;
      monster_hit_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      hit_type_q    <= hit_type_d;
      fire_q        <= fire_d;
      monster_hit_q <= monster_hit_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fireCollision = fire_q;
  assign monster_hit   = monster_hit_q;
  assign hit_type      = hit_type_q;

endmodule

// File: doc/shot_collision_ctrl.md
Name: shot_collision_ctrl

Overview:
- Downstream partner of the shot mover. It watches the live shot's position and the per-pixel drawing requests, and decides once per frame whether the shot must die.
- It drives the mover's fireCollision input and reports monster kills to the score/monster logic.
- Death causes: monster hit, dirt or bag hit, leaving the board, or flight timeout.

Parameters:
- BOARD_LEFT, 32, leftmost legal shot pixel X
- BOARD_TOP, 160, topmost legal shot pixel Y
- BOARD_RIGHT, 607, rightmost legal shot pixel X
- BOARD_BOTTOM, 479, bottommost legal shot pixel Y
- SHOT_SIZE, 8, shot sprite width and height in pixels
- MAX_FLIGHT_FRAMES, 60, frames a shot may live before forced retire

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- shot_alive  in  1  alive flag from the shot mover
- shot_topLeftX  in  11  shot top-left X, unsigned; negative positions wrap to large values
- shot_topLeftY  in  11  shot top-left Y, same encoding
- shot_dr  in  1  shot drawing request for the current pixel
- monster_dr  in  1  monster drawing request for the current pixel
- dirt_dr  in  1  undug-dirt drawing request for the current pixel
- bag_dr  in  1  gold-bag drawing request for the current pixel
- fireCollision  out  1  retire request to the shot mover; level signal
- monster_hit  out  1  one-cycle pulse when the shot killed a monster
- hit_type  out  2  cause of the last retire: 00 none, 01 monster, 10 obstacle, 11 bounds/timeout

Behaviour:
- Reset (async, reset=1): state IDLE, accumulators cleared, flight counter 0.
  - Outputs at reset: fireCollision=0, monster_hit=0, hit_type=00.
- Per-pixel accumulators, sticky within a frame:
  - mon_seen is set on any cycle with shot_dr && monster_dr.
  - obs_seen is set on any cycle with shot_dr && (dirt_dr || bag_dr).
  - Both clear on startOfFrame, after being sampled.
  - A coincidence in the same cycle as startOfFrame counts toward the new frame.
- Bounds check (combinational, evaluated only at startOfFrame). The shot is out of bounds when any of these holds:
  - shot_topLeftX < BOARD_LEFT
  - shot_topLeftY < BOARD_TOP
  - shot_topLeftX + SHOT_SIZE - 1 > BOARD_RIGHT
  - shot_topLeftY + SHOT_SIZE - 1 > BOARD_BOTTOM
  - Sums are computed in 12 bits, so no wrap.
- State machine:
  - IDLE: flight counter held at 0. Go to FLYING on shot_alive=1.
  - FLYING: the flight counter increments on each startOfFrame and saturates at MAX_FLIGHT_FRAMES.
    - On startOfFrame, causes are evaluated in priority order: mon_seen, then obs_seen, then out of bounds, then counter == MAX_FLIGHT_FRAMES.
    - On any cause: go to RETIRE next cycle, assert fireCollision, load hit_type (01 / 10 / 11 / 11).
    - For a monster cause only, pulse monster_hit for exactly one cycle (the cycle RETIRE is entered).
    - If shot_alive drops while in FLYING (external kill): go to IDLE with no outputs.
  - RETIRE: fireCollision is held at 1 while shot_alive=1. When shot_alive=0, drop fireCollision and go to IDLE the next cycle.
- hit_type is held until the next retire; it is cleared only by reset.
- Only one retire per shot: monster_hit can never pulse twice for the same shot.
- Mid-flight reset returns to IDLE immediately; the next shot starts a fresh flight count.
- Simultaneous causes: the highest priority cause wins. For example, a monster hit and out of bounds in the same frame give hit_type=01 and a monster_hit pulse.

Decomposition:
- Shared package shot_pkg holds:
  - the hit_type enum: HIT_NONE, HIT_MONSTER, HIT_OBSTACLE, HIT_EXPIRED
  - the state enum: IDLE, FLYING, RETIRE
  - board-bound default constants shared with the shot mover
- One sub-module is natural: shot_frame_accum. It owns the mon_seen/obs_seen sticky flags and their startOfFrame clear.
- The FSM, bounds compare and flight counter stay in the top module.

Test Plan:
- Reset: assert reset mid-RETIRE with fireCollision=1 -> all outputs 0 asynchronously; state IDLE after release.
- Monster hit: shot at (200,300), shot_dr&&monster_dr on 3 pixels in one frame.
  - At the next startOfFrame: fireCollision=1 one cycle later, monster_hit high exactly 1 cycle, hit_type=01.
  - Drop shot_alive -> fireCollision=0 the following cycle.
- Bounds, left edge: shot_topLeftX=31, no drawing overlaps -> retire at the next startOfFrame, hit_type=11, monster_hit=0.
- Bounds, right edge: X=600 (600+7=607) -> no retire; X=601 -> retire.
- Bounds, wrapped position: X=2047 -> retire.
- Timeout: shot alive with no hits or bounds violations -> retire exactly at the 60th startOfFrame after entering FLYING, hit_type=11.
- Priority/accumulator edges:
  - obstacle plus monster in the same frame -> hit_type=01.
  - a coincidence only on the startOfFrame cycle -> ignored for the current evaluation, acted on at the next frame.
- External kill: shot_alive drops in FLYING -> IDLE, fireCollision stays 0, hit_type unchanged.
